alu_seq_exec: RTL and testbench

//   Sequential execute-stage ALU. Consumes the 6-bit funct code produced by ALU_Control

---
 rtl/alu_seq_exec.sv | 121 ++++++++++++
 tb/tb_alu_seq_exec.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_exec.sv
// Sequential execute-stage ALU: single-cycle ADDU/SUBU/SLT, iterative SLL/SLLV shifter.
// One operation in flight, valid/ready handshake on both sides.
//   state | meaning
//   IDLE  | waiting for an operation (in_ready=1)
//   SHIFT | iterative left shift in progress
//   DONE  | result held until out_ready (out_valid=1)
module alu_seq_exec #(
  parameter int DATA_W        = 32,
  parameter int SHIFT_PER_CYC = 1,
  localparam int SHW          = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [SHW-1:0]    shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_SLL  = 6'b100001;
  localparam logic [5:0] F_SLLV = 6'b110101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [SHW:0] STEP_MAX = (SHW+1)'(SHIFT_PER_CYC);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] result_nxt;
  logic              zero_nxt;
  logic              illegal_nxt;
  logic [SHW-1:0]    remaining, remaining_nxt;
  logic [SHW-1:0]    amount;
  logic [SHW:0]      step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    result_nxt    = result;
    zero_nxt      = zero;
    illegal_nxt   = illegal;
    remaining_nxt = remaining;
    step          = '0;
    amount        = (funct == F_SLLV) ? src1[SHW-1:0] : shamt;

    case (state)
      IDLE: begin
        // operands are only looked at here, so activity in other states cannot leak in
        if (in_valid) begin
          state_nxt   = DONE;
          illegal_nxt = 1'b0;
          case (funct)
            F_ADDU: result_nxt = src1 + src2;
            F_SUBU: result_nxt = src1 - src2;
            F_SLT:  result_nxt = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(src2))};
            F_SLL, F_SLLV: begin
              result_nxt = src2;
              if (amount != '0) begin
                remaining_nxt = amount;
                state_nxt     = SHIFT;
              end
            end
            default: begin
              result_nxt  = '0;
              illegal_nxt = 1'b1;
            end
          endcase
          zero_nxt = (result_nxt == '0);
        end
      end

      SHIFT: begin
        step          = ({1'b0, remaining} > STEP_MAX) ? STEP_MAX : {1'b0, remaining};
        result_nxt    = result << step;
        remaining_nxt = remaining - step[SHW-1:0];
        zero_nxt      = (result_nxt == '0);
        if (remaining_nxt == '0) state_nxt = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_nxt   = IDLE;
          illegal_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      remaining <= '0;
    end else begin
      result    <= result_nxt;
      zero      <= zero_nxt;
      illegal   <= illegal_nxt;
      remaining <= remaining_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: two instances (1 and 4 shift bits per cycle) driven with
// directed and random operations, checked against an arithmetic reference model.
module tb_alu_seq_exec;

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_SLL  = 6'b100001;
  localparam logic [5:0] F_SLLV = 6'b110101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [5:0]  funct    [2];
  logic [31:0] src1     [2];
  logic [31:0] src2     [2];
  logic [4:0]  shamt    [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic [31:0] result   [2];
  logic        zero     [2];
  logic        illegal  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.DATA_W(32), .SHIFT_PER_CYC(1)) u_spc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .funct(funct[0]), .src1(src1[0]), .src2(src2[0]), .shamt(shamt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
    .zero(zero[0]), .illegal(illegal[0]));

  alu_seq_exec #(.DATA_W(32), .SHIFT_PER_CYC(4)) u_spc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .funct(funct[1]), .src1(src1[1]), .src2(src2[1]), .shamt(shamt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
    .zero(zero[1]), .illegal(illegal[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] f);
    return f == F_ADDU || f == F_SUBU || f == F_SLT || f == F_SLL || f == F_SLLV;
  endfunction

  function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_ADDU:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      F_SUBU:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      F_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      F_SLL:   return 32'((64'(b) * (64'd1 << sh)) % 64'h1_0000_0000);
      F_SLLV:  return 32'((64'(b) * (64'd1 << a[4:0])) % 64'h1_0000_0000);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] f, input logic [31:0] a,
                                     input logic [4:0] sh, input int spc);
    int amt;
    if (f == F_SLL)       amt = int'(sh);
    else if (f == F_SLLV) amt = int'(a[4:0]);
    else                  amt = 0;
    return 1 + (amt + spc - 1) / spc;
  endfunction

  // Entered and left at posedge+1 with the unit idle.
  task automatic run_op(input int u, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
    logic [31:0] exp_res;
    int exp_lat, lat, spc;
    spc     = (u == 0) ? 1 : 4;
    exp_res = ref_result(f, a, b, sh);
    exp_lat = ref_latency(f, a, sh, spc);

    check("in_ready_idle", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1; funct[u] = f; src1[u] = a; src2[u] = b; shamt[u] = sh;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    funct[u] = 6'($urandom); src1[u] = $urandom; src2[u] = $urandom; shamt[u] = 5'($urandom);
    lat = 1;
    while (!out_valid[u] && lat < 200) begin
      check("in_ready_busy", 32'(in_ready[u]), 32'd0);
      src1[u] = $urandom; src2[u] = $urandom; in_valid[u] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid[u] = 1'b0;
    check("out_valid_seen", 32'(out_valid[u]), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", result[u], exp_res);
    check("zero", 32'(zero[u]), 32'(exp_res == 32'd0));
    check("illegal", 32'(illegal[u]), 32'(!is_legal(f)));
    check("in_ready_done", 32'(in_ready[u]), 32'd0);

    for (int h = 0; h < hold; h++) begin
      in_valid[u] = 1'b1; funct[u] = 6'($urandom); src1[u] = $urandom; src2[u] = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid[u]), 32'd1);
      check("hold_result", result[u], exp_res);
      check("hold_zero", 32'(zero[u]), 32'(exp_res == 32'd0));
      check("hold_illegal", 32'(illegal[u]), 32'(!is_legal(f)));
    end

    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    check("post_hs_valid", 32'(out_valid[u]), 32'd0);
    check("post_hs_ready", 32'(in_ready[u]), 32'd1);
    check("post_hs_illegal", 32'(illegal[u]), 32'd0);
    in_valid[u] = 1'b0;
  endtask

  logic [5:0] legal_tab [5];

  initial begin
    legal_tab[0] = F_ADDU; legal_tab[1] = F_SUBU; legal_tab[2] = F_SLT;
    legal_tab[3] = F_SLL;  legal_tab[4] = F_SLLV;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; out_ready[u] = 1'b0; funct[u] = '0;
      src1[u] = '0; src2[u] = '0; shamt[u] = '0;
    end

    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", 32'(in_ready[u]), 32'd1);
      check("rst_out_valid", 32'(out_valid[u]), 32'd0);
      check("rst_result", result[u], 32'd0);
      check("rst_zero", 32'(zero[u]), 32'd0);
      check("rst_illegal", 32'(illegal[u]), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, F_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
    run_op(0, F_SUBU, 32'd5, 32'd7, 5'd0, 0);
    run_op(0, F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    run_op(0, F_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 0);
    run_op(0, F_SLL, 32'h0, 32'h3, 5'd4, 0);
    run_op(0, F_SLLV, 32'd31, 32'd1, 5'd0, 0);
    run_op(0, F_SLLV, 32'h20, 32'hABCD, 5'd0, 0);
    run_op(1, F_SLL, 32'h0, 32'h1234_5678, 5'd9, 0);
    run_op(1, F_SLLV, 32'd31, 32'h3, 5'd0, 1);
    run_op(0, 6'b000000, 32'h55, 32'h66, 5'd3, 0);
    run_op(0, F_ADDU, 32'd10, 32'd20, 5'd0, 3);
    run_op(0, F_SLL, 32'h0, 32'hFFFF_FFFF, 5'd31, 2);

    for (int i = 0; i < 150; i++) begin
      int u;
      logic [5:0] f;
      logic [31:0] a, b;
      u = int'($urandom_range(0, 1));
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_tab[$urandom_range(0, 4)];
      a = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      run_op(u, f, a, b, 5'($urandom), int'($urandom_range(0, 3)));
    end

    // reset in the middle of a long shift
    in_valid[0] = 1'b1; funct[0] = F_SLL; src2[0] = 32'h1; shamt[0] = 5'd20;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_result", result[0], 32'd0);
    check("midrst_zero", 32'(zero[0]), 32'd0);
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      check("midrst_no_emit", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, F_ADDU, 32'd2, 32'd3, 5'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
